fir_coe_ctrl: RTL and testbench

// Sequences run-time coefficient reloads for the double-banked fir_filter. Accepts
// one coefficient set as a valid/ready stream, writes it into the inactive (shadow)

---
 rtl/fir_coe_ctrl_if.sv | 13 +
 rtl/fir_coe_ctrl.sv | 150 +++++++++++++++
 tb/tb_fir_coe_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fir_coe_ctrl_if.sv
// Coefficient beat stream between the config source and fir_coe_ctrl.
// The source drives data/valid/last; the controller answers with a registered ready.
interface fir_coe_ctrl_if #(
  parameter int COE_WIDTH = 16
) ();
  logic [COE_WIDTH-1:0] data;
  logic                 valid;
  logic                 last;
  logic                 ready;

  modport master (output data, valid, last, input  ready);
  modport slave  (input  data, valid, last, output ready);
endinterface

// File: rtl/fir_coe_ctrl.sv
// Run-time coefficient reload sequencer for the double-banked fir_filter: loads the
// shadow bank, swaps on a sample boundary, then masks output until the taps are clean.
module fir_coe_ctrl #(
  parameter int COE_WIDTH    = 16,
  parameter int COE_NUM      = 66,
  parameter int FLUSH_CYCLES = COE_NUM
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       sample_en_i,
  fir_coe_ctrl_if.slave              coe,
  input  logic                       abort_i,
  output logic                       coe_wr_en_o,
  output logic                       coe_wr_bank_o,
  output logic [$clog2(COE_NUM)-1:0] coe_wr_addr_o,
  output logic [COE_WIDTH-1:0]       coe_wr_data_o,
  output logic                       bank_sel_o,
  output logic                       out_valid_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int ADDR_W = $clog2(COE_NUM);
  localparam int IDX_W  = $clog2(COE_NUM + 1);
  localparam int CNT_W  = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(COE_NUM - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES);

  typedef enum logic [1:0] {FLUSH, IDLE, LOAD, SWAP_WAIT} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  bank_q, bank_d;
  logic                  ov_q, ov_d;
  logic                  rdy_q;
  logic                  err_q, err_d;
  logic                  wr_en_q, wr_d;
  logic [ADDR_W-1:0]     wr_addr_q;
  logic [COE_WIDTH-1:0]  wr_data_q;
  logic                  acc;

  assign acc = coe.valid & rdy_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    ov_d    = ov_q;
    err_d   = 1'b0;
    wr_d    = 1'b0;
    unique case (state_q)
      FLUSH: begin
        if (sample_en_i && cnt_q != '0)
          cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0 || (sample_en_i && cnt_q == CNT_W'(1))) begin
          state_d = IDLE;
          ov_d    = 1'b1;
        end
      end
      IDLE: begin
        // idx is always 0 here, so beat 0 lands on address 0
        if (acc && !abort_i) begin
          wr_d = 1'b1;
          if (coe.last) begin
            err_d = 1'b1;
          end else begin
            state_d = LOAD;
            idx_d   = IDX_W'(1);
          end
        end
      end
      LOAD: begin
        if (abort_i) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (acc) begin
          wr_d = 1'b1;
          if (idx_q == IDX_LAST && coe.last) begin
            state_d = SWAP_WAIT;
            idx_d   = '0;
          end else if (idx_q == IDX_LAST || coe.last) begin
            err_d   = 1'b1;
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      SWAP_WAIT: begin
        // swap only on a sample strobe so no output mixes the two banks mid-sample
        if (sample_en_i) begin
          bank_d  = ~bank_q;
          cnt_d   = CNT_INIT;
          ov_d    = (FLUSH_CYCLES == 0);
          state_d = (FLUSH_CYCLES == 0) ? IDLE : FLUSH;
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= FLUSH;
      idx_q     <= '0;
      cnt_q     <= CNT_INIT;
      bank_q    <= 1'b0;
      ov_q      <= 1'b0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      ov_q    <= ov_d;
      rdy_q   <= (state_d == IDLE) || (state_d == LOAD);
      err_q   <= err_d;
      wr_en_q <= wr_d;
      if (wr_d) begin
        wr_addr_q <= idx_q[ADDR_W-1:0];
        wr_data_q <= coe.data;
      end
    end
  end

  assign coe.ready     = rdy_q;
  assign coe_wr_en_o   = wr_en_q;
  assign coe_wr_bank_o = ~bank_q;
  assign coe_wr_addr_o = wr_addr_q;
  assign coe_wr_data_o = wr_data_q;
  assign bank_sel_o    = bank_q;
  assign out_valid_o   = ov_q;
  assign busy_o        = (state_q != IDLE);
  assign err_o         = err_q;

  a_rdy_state: assert property (@(posedge clk_i)
    rdy_q |-> (state_q == IDLE || state_q == LOAD));

  a_swap_toggle: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == SWAP_WAIT && sample_en_i) |=> (bank_q != $past(bank_q)));

endmodule

// File: tb/tb_fir_coe_ctrl.sv
// Randomized reload sequences for fir_coe_ctrl checked against a transaction-level
// model: expected write queue, expected active bank and sample-pulse flush counting.
module tb_fir_coe_ctrl;
  localparam int W = 16;
  localparam int N = 66;

  typedef struct packed {
    logic        b;
    logic [6:0]  a;
    logic [15:0] d;
  } wr_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         sample_en;
  logic         abort;
  logic         wr_en, wr_bank, bank_sel, out_valid, busy, err;
  logic [6:0]   wr_addr;
  logic [W-1:0] wr_data;

  fir_coe_ctrl_if #(.COE_WIDTH(W)) coe_if ();

  fir_coe_ctrl #(.COE_WIDTH(W), .COE_NUM(N), .FLUSH_CYCLES(N)) dut (
    .clk_i(clk), .rst_i(rst), .sample_en_i(sample_en), .coe(coe_if), .abort_i(abort),
    .coe_wr_en_o(wr_en), .coe_wr_bank_o(wr_bank), .coe_wr_addr_o(wr_addr),
    .coe_wr_data_o(wr_data), .bank_sel_o(bank_sel), .out_valid_o(out_valid),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  int  n_chk = 0, n_err = 0;
  int  cyc = 0, err_seen = 0;
  int  se_mode = 0;   // 0 always, 1 every 4th cycle, 2 random
  bit  se_edge;
  bit  bank_exp = 1'b0;
  wr_t wq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: sample outputs after the edge, check writes, pick the next strobe.
  task automatic tick();
    wr_t e;
    se_edge = sample_en;
    @(posedge clk);
    #1;
    cyc++;
    if (wr_en) begin
      if (wq.size() == 0) chk("wr_unexpected", 32'(wr_en), 32'd0);
      else begin
        e = wq.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.a));
        chk("wr_data", 32'(wr_data), 32'(e.d));
        chk("wr_bank", 32'(wr_bank), 32'(e.b));
      end
    end
    if (err) err_seen++;
    case (se_mode)
      0:       sample_en = 1'b1;
      1:       sample_en = (cyc % 4 == 0);
      default: sample_en = ($urandom_range(2) == 0);
    endcase
  endtask

  // Offers up to n beats; stops after a beat carrying last or abort.
  task automatic send_set(input int n, input int last_at, input int abort_at,
                          input int gap_pct, input bit seq_data);
    int  i = 0;
    int  guard;
    bit  stop = 1'b0;
    wr_t e;
    while (i < n && !stop) begin
      if ($urandom_range(99) < gap_pct) begin
        coe_if.valid = 1'b0;
        tick();
      end else begin
        coe_if.data  = seq_data ? W'(i + 1) : W'($urandom);
        coe_if.valid = 1'b1;
        coe_if.last  = (i == last_at);
        abort        = (i == abort_at);
        guard = 0;
        while (!coe_if.ready && guard < 200) begin
          tick();
          guard++;
        end
        if (guard >= 200) begin
          chk("ready_timeout", 32'd0, 32'd1);
          stop = 1'b1;
        end else begin
          if (!abort) begin
            e.b = ~bank_exp;
            e.a = 7'(i);
            e.d = coe_if.data;
            wq.push_back(e);
          end
          stop = abort || coe_if.last;
          tick();
          i++;
        end
        coe_if.valid = 1'b0;
        coe_if.last  = 1'b0;
        abort        = 1'b0;
      end
    end
  endtask

  task automatic expect_swap();
    int guard = 0;
    bit done  = 1'b0;
    while (!done && guard < 1000) begin
      tick();
      guard++;
      if (se_edge) begin
        bank_exp = ~bank_exp;
        chk("swap_bank", 32'(bank_sel), 32'(bank_exp));
        chk("swap_out_valid", 32'(out_valid), 32'd0);
        done = 1'b1;
      end else begin
        chk("swap_hold_bank", 32'(bank_sel), 32'(bank_exp));
      end
    end
    if (!done) chk("swap_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_flush(input int nflush);
    int p = 0, guard = 0;
    while (p < nflush && guard < 3000) begin
      tick();
      guard++;
      if (se_edge) p++;
      chk("flush_out_valid", 32'(out_valid), 32'(p == nflush));
      chk("flush_busy", 32'(busy), 32'(p != nflush));
      chk("flush_ready", 32'(coe_if.ready), 32'(p == nflush));
      chk("flush_bank", 32'(bank_sel), 32'(bank_exp));
    end
    if (p < nflush) chk("flush_timeout", 32'(p), 32'(nflush));
  endtask

  task automatic good_load(input bit seq, input int gap);
    send_set(N, N - 1, -1, gap, seq);
    chk("ready_drop", 32'(coe_if.ready), 32'd0);
    chk("busy_swap_wait", 32'(busy), 32'd1);
    expect_swap();
    expect_flush(N);
    chk("wq_empty_good", 32'(wq.size()), 32'd0);
  endtask

  task automatic bad_load(input int last_at, input int abort_at);
    int e0 = err_seen;
    send_set(N, last_at, abort_at, 20, 1'b0);
    tick();
    chk("err_count", 32'(err_seen - e0), (abort_at >= 0) ? 32'd0 : 32'd1);
    chk("bad_busy", 32'(busy), 32'd0);
    chk("bad_bank", 32'(bank_sel), 32'(bank_exp));
    chk("bad_out_valid", 32'(out_valid), 32'd1);
    chk("bad_ready", 32'(coe_if.ready), 32'd1);
    chk("wq_empty_bad", 32'(wq.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; sample_en = 1'b1; abort = 1'b0;
    coe_if.data = '0; coe_if.valid = 1'b0; coe_if.last = 1'b0;
    repeat (3) tick();
    chk("rst_bank", 32'(bank_sel), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(coe_if.ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    expect_flush(N);

    // sequential values, back-to-back beats
    good_load(1'b1, 0);
    // random gaps, strobe every 4th cycle
    se_mode = 1;
    good_load(1'b0, 30);
    // early last, missing last, abort, then a clean load
    se_mode = 0;
    bad_load(10, -1);
    bad_load(-1, -1);
    bad_load(0, -1);
    bad_load(N - 1, 30);
    good_load(1'b0, 10);

    // reset during the flush of a reload
    send_set(N, N - 1, -1, 0, 1'b0);
    expect_swap();
    repeat (30) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bank_exp = 1'b0;
    chk("midflush_rst_bank", 32'(bank_sel), 32'd0);
    chk("midflush_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midflush_rst_busy", 32'(busy), 32'd1);
    expect_flush(N);

    for (int k = 0; k < 8; k++) begin
      se_mode = $urandom_range(2);
      case ($urandom_range(3))
        0:       good_load(1'b0, $urandom_range(40));
        1:       bad_load($urandom_range(N - 2), -1);
        2:       bad_load(-1, -1);
        default: bad_load(N - 1, 1 + $urandom_range(N - 2));
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
